// File: rtl/band_peak_detect_pkg.sv
// Shared widths and band bin constants for the FFT peak detection slice.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package band_peak_detect_pkg;

  localparam int DATLEN        = 12;
  localparam int FFT_VLEN      = 16;
  localparam int FFT_VLEN_LOG2 = 4;

  // 730 nm channel occupies bins A_LO..A_HI, 850 nm channel B_LO..B_HI
  localparam int A_LO = 2;
  localparam int A_HI = 5;
  localparam int B_LO = 6;
  localparam int B_HI = 9;

  // Per-beat context that rides alongside the magnitude pipeline
  typedef struct packed {
    logic [FFT_VLEN_LOG2-1:0] idx;        // bin index of this beat
    logic                     last;       // beat is bin FFT_VLEN-1
    logic                     ovf;        // overflow seen so far in this frame
    logic                     short_end;  // frame ended early (not a data beat)
  } side_t;

  function automatic logic in_band(input logic [FFT_VLEN_LOG2-1:0] idx,
                                   input int lo, input int hi);
    int i;
    i = int'(idx);
    return (i >= lo) && (i <= hi);
  endfunction

endpackage

// File: rtl/band_peak_detect_if.sv
// Bin stream in, per-frame band peaks and status strobes out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the FFT stream cannot be stalled.
interface band_peak_detect_if;
  import band_peak_detect_pkg::*;

  logic [2*DATLEN-1:0]      fft_x;
  logic                     fft_nd;
  logic                     fft_ovf;
  logic [DATLEN-1:0]        max730;
  logic [DATLEN-1:0]        max850;
  logic [FFT_VLEN_LOG2-1:0] idx730;
  logic [FFT_VLEN_LOG2-1:0] idx850;
  logic                     peak_valid;
  logic                     frame_err;

  // Bin source / result consumer side
  modport master (
    output fft_x, fft_nd, fft_ovf,
    input  max730, max850, idx730, idx850, peak_valid, frame_err
  );

  // Peak detector side
  modport slave (
    input  fft_x, fft_nd, fft_ovf,
    output max730, max850, idx730, idx850, peak_valid, frame_err
  );

endinterface

// File: rtl/cplx_mag_est.sv
// Complex magnitude estimate: max(|re|,|im|) + min(|re|,|im|)/2, saturated to W bits.
// Latency: 2 cycles (abs register, then magnitude register); sideband delayed to match.
// Backpressure: none; accepts one sample every cycle.
module cplx_mag_est
  import band_peak_detect_pkg::*;
#(
  parameter int W    = DATLEN,
  parameter int SB_W = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_vld,
  input  logic [2*W-1:0]  in_dat,
  input  logic [SB_W-1:0] in_sb,
  output logic            out_vld,
  output logic [W-1:0]    out_dat,
  output logic [SB_W-1:0] out_sb
);

  // The most negative input maps to 2^(W-1), which still fits W unsigned bits
  function automatic logic [W-1:0] abs_u(input logic [W-1:0] x);
    return x[W-1] ? (~x + W'(1)) : x;
  endfunction

  logic            s1_vld;
  logic [W-1:0]    s1_abs_re;
  logic [W-1:0]    s1_abs_im;
  logic [SB_W-1:0] s1_sb;

  logic [W-1:0]    mx;
  logic [W-1:0]    mn;
  logic [W:0]      sum;
  logic [W-1:0]    mag_sat;

  // Stage 1: register component magnitudes with their sideband
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_vld    <= 1'b0;
      s1_abs_re <= '0;
      s1_abs_im <= '0;
      s1_sb     <= '0;
    end else begin
      s1_vld    <= in_vld;
      s1_abs_re <= abs_u(in_dat[2*W-1:W]);
      s1_abs_im <= abs_u(in_dat[W-1:0]);
      s1_sb     <= in_sb;
    end
  end

  // Alpha-max-beta-min at W+1 bits so the saturation check sees the carry
  always_comb begin
    mx      = (s1_abs_re > s1_abs_im) ? s1_abs_re : s1_abs_im;
    mn      = (s1_abs_re > s1_abs_im) ? s1_abs_im : s1_abs_re;
    sum     = {1'b0, mx} + ({1'b0, mn} >> 1);
    mag_sat = sum[W] ? {W{1'b1}} : sum[W-1:0];
  end

  // Stage 2: register saturated magnitude
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      out_sb  <= '0;
    end else begin
      out_vld <= s1_vld;
      out_dat <= mag_sat;
      out_sb  <= s1_sb;
    end
  end

endmodule

// File: rtl/band_peak_detect.sv
// Per-frame peak magnitude and bin index inside two bin bands of an FFT frame.
// Latency: last bin beat -> peak_valid 4 cycles; early fft_nd drop -> frame_err 4 cycles later.
// Backpressure: none; frames may arrive back-to-back with zero gap.
module band_peak_detect (
  input logic               clk,
  input logic               reset_n,
  band_peak_detect_if.slave bus
);
  import band_peak_detect_pkg::*;

  localparam logic [FFT_VLEN_LOG2-1:0] LAST_BIN = FFT_VLEN_LOG2'(FFT_VLEN - 1);

  logic [FFT_VLEN_LOG2-1:0] bin_cnt;
  logic                     ovf_lat;
  logic                     ovf_now;
  side_t                    s0_sb;

  logic                     s2_vld;
  logic [DATLEN-1:0]        s2_mag;
  side_t                    s2_sb;

  logic [DATLEN-1:0]        run_a, run_b;
  logic [FFT_VLEN_LOG2-1:0] ridx_a, ridx_b;
  logic [DATLEN-1:0]        nxt_run_a, nxt_run_b;
  logic [FFT_VLEN_LOG2-1:0] nxt_idx_a, nxt_idx_b;
  logic                     frame_start;
  logic                     pub_pend, err_pend;

  logic [DATLEN-1:0]        max730_q, max850_q;
  logic [FFT_VLEN_LOG2-1:0] idx730_q, idx850_q;
  logic                     peak_valid_q, frame_err_q;

  // Beat context: overflow history is ignored on bin 0 so a new frame starts clean
  always_comb begin
    ovf_now         = bus.fft_ovf | ((bin_cnt != '0) & ovf_lat);
    s0_sb           = '0;
    s0_sb.idx       = bin_cnt;
    s0_sb.last      = bus.fft_nd && (bin_cnt == LAST_BIN);
    s0_sb.ovf       = ovf_now;
    s0_sb.short_end = !bus.fft_nd && (bin_cnt != '0);
  end

  // Bin counter and overflow latch; counter wraps so frames can run back-to-back
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bin_cnt <= '0;
      ovf_lat <= 1'b0;
    end else if (bus.fft_nd) begin
      bin_cnt <= bin_cnt + FFT_VLEN_LOG2'(1);
      ovf_lat <= ovf_now;
    end else begin
      bin_cnt <= '0;
      ovf_lat <= 1'b0;
    end
  end

  cplx_mag_est #(
    .W    (DATLEN),
    .SB_W ($bits(side_t))
  ) u_mag (
    .clk     (clk),
    .reset_n (reset_n),
    .in_vld  (bus.fft_nd),
    .in_dat  (bus.fft_x),
    .in_sb   (s0_sb),
    .out_vld (s2_vld),
    .out_dat (s2_mag),
    .out_sb  (s2_sb)
  );

  // Band update: the first bin of each band always loads, later bins only on strictly larger
  always_comb begin
    frame_start = s2_vld && (s2_sb.idx == '0);
    nxt_run_a   = frame_start ? '0 : run_a;
    nxt_idx_a   = frame_start ? '0 : ridx_a;
    nxt_run_b   = frame_start ? '0 : run_b;
    nxt_idx_b   = frame_start ? '0 : ridx_b;
    if (s2_vld && in_band(s2_sb.idx, A_LO, A_HI) &&
        ((int'(s2_sb.idx) == A_LO) || (s2_mag > nxt_run_a))) begin
      nxt_run_a = s2_mag;
      nxt_idx_a = s2_sb.idx;
    end
    if (s2_vld && in_band(s2_sb.idx, B_LO, B_HI) &&
        ((int'(s2_sb.idx) == B_LO) || (s2_mag > nxt_run_b))) begin
      nxt_run_b = s2_mag;
      nxt_idx_b = s2_sb.idx;
    end
  end

  // Stage 3: running band peaks plus the end-of-frame verdict
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_a    <= '0;
      run_b    <= '0;
      ridx_a   <= '0;
      ridx_b   <= '0;
      pub_pend <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      if (s2_sb.short_end) begin
        run_a  <= '0;
        run_b  <= '0;
        ridx_a <= '0;
        ridx_b <= '0;
      end else begin
        run_a  <= nxt_run_a;
        run_b  <= nxt_run_b;
        ridx_a <= nxt_idx_a;
        ridx_b <= nxt_idx_b;
      end
      pub_pend <= s2_vld && s2_sb.last && !s2_sb.ovf;
      err_pend <= (s2_vld && s2_sb.last && s2_sb.ovf) || s2_sb.short_end;
    end
  end

  // Output stage: publish completed peaks; hold outputs on a discarded frame
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      max730_q     <= '0;
      max850_q     <= '0;
      idx730_q     <= '0;
      idx850_q     <= '0;
      peak_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      peak_valid_q <= pub_pend;
      frame_err_q  <= err_pend;
      if (pub_pend) begin
        max730_q <= run_a;
        idx730_q <= ridx_a;
        max850_q <= run_b;
        idx850_q <= ridx_b;
      end
    end
  end

  assign bus.max730     = max730_q;
  assign bus.max850     = max850_q;
  assign bus.idx730     = idx730_q;
  assign bus.idx850     = idx850_q;
  assign bus.peak_valid = peak_valid_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_band_peak_detect.sv
// Directed bench for band_peak_detect with a strobe scoreboard.
// Latency: expected strobe cycle is stored with each scoreboard entry.
// Backpressure: n/a (the stream is driven continuously).
module tb_band_peak_detect;
  import band_peak_detect_pkg::*;

  typedef struct {
    bit is_err;
    int m730;
    int i730;
    int m850;
    int i850;
    int at;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb[$];
  int   fr_re[FFT_VLEN];
  int   fr_im[FFT_VLEN];
  int   h730, hi730, h850, hi850;

  band_peak_detect_if dut_if();

  band_peak_detect dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int mag_model(input int re, input int im);
    int a, b, mx, mn, s;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    s  = mx + mn / 2;
    if (s > 4095) s = 4095;
    return s;
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < FFT_VLEN; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
  endtask

  task automatic drive_beat(input int re, input int im, input bit ovf);
    @(negedge clk);
    dut_if.fft_x   = {DATLEN'(re), DATLEN'(im)};
    dut_if.fft_nd  = 1'b1;
    dut_if.fft_ovf = ovf;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dut_if.fft_x   = '0;
      dut_if.fft_nd  = 1'b0;
      dut_if.fft_ovf = 1'b0;
    end
  endtask

  // Drives nb beats from fr_re/fr_im and queues the strobe the frame should produce
  task automatic run_frame(input int nb, input int ovf_beat);
    int last_at, ba, bb, ia, ib, m;
    last_at = 0;
    for (int b = 0; b < nb; b++) begin
      drive_beat(fr_re[b], fr_im[b], b == ovf_beat);
      last_at = cyc;
    end
    if (nb < FFT_VLEN) begin
      sb.push_back('{1'b1, h730, hi730, h850, hi850, last_at + 5});
    end else if (ovf_beat >= 0) begin
      sb.push_back('{1'b1, h730, hi730, h850, hi850, last_at + 4});
    end else begin
      ba = -1; bb = -1; ia = 0; ib = 0;
      for (int b = A_LO; b <= A_HI; b++) begin
        m = mag_model(fr_re[b], fr_im[b]);
        if (m > ba) begin ba = m; ia = b; end
      end
      for (int b = B_LO; b <= B_HI; b++) begin
        m = mag_model(fr_re[b], fr_im[b]);
        if (m > bb) begin bb = m; ib = b; end
      end
      h730 = ba; hi730 = ia; h850 = bb; hi850 = ib;
      sb.push_back('{1'b0, h730, hi730, h850, hi850, last_at + 4});
    end
  endtask

  task automatic chk_outs(input string tag, input int m730, input int i730,
                          input int m850, input int i850);
    chk({tag, "_max730"}, 32'(dut_if.max730), m730);
    chk({tag, "_idx730"}, 32'(dut_if.idx730), i730);
    chk({tag, "_max850"}, 32'(dut_if.max850), m850);
    chk({tag, "_idx850"}, 32'(dut_if.idx850), i850);
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (dut_if.peak_valid === 1'b1 || dut_if.frame_err === 1'b1) begin
      chk("strobe_exclusive", 32'(dut_if.peak_valid & dut_if.frame_err), 0);
      chk("strobe_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_frame_err", 32'(dut_if.frame_err), 32'(e.is_err));
        chk("sb_cycle", cyc, e.at);
        chk_outs("sb", e.m730, e.i730, e.m850, e.i850);
      end
    end
  end

  initial begin
    reset_n        = 1'b0;
    dut_if.fft_x   = '0;
    dut_if.fft_nd  = 1'b0;
    dut_if.fft_ovf = 1'b0;
    h730 = 0; hi730 = 0; h850 = 0; hi850 = 0;
    repeat (3) @(negedge clk);
    chk_outs("reset", 0, 0, 0, 0);
    chk("reset_peak_valid", 32'(dut_if.peak_valid), 0);
    chk("reset_frame_err", 32'(dut_if.frame_err), 0);
    reset_n = 1'b1;
    idle(2);

    // Frame 1: basic peaks in both bands
    clear_frame();
    fr_re[3] = 100;  fr_im[3] = -40;
    fr_re[7] = -200;
    run_frame(16, -1);
    idle(6);
    chk_outs("f1", 120, 3, 200, 7);

    // Frame 2: most negative input and near-full-scale bins
    clear_frame();
    fr_re[4] = -2048; fr_im[4] = -2048;
    fr_re[5] = 2047;  fr_im[5] = 2047;
    run_frame(16, -1);
    idle(6);
    chk("f2_max730", 32'(dut_if.max730), 3072);
    chk("f2_idx730", 32'(dut_if.idx730), 4);

    // Frame 3: equal magnitudes in band B keep the lower bin
    clear_frame();
    fr_re[2] = 10;
    fr_re[6] = 50; fr_im[6] = 50;
    fr_re[8] = 50; fr_im[8] = 50;
    run_frame(16, -1);
    idle(6);
    chk_outs("f3", 10, 2, 75, 6);

    // Short frame: 10 beats then fft_nd drops; outputs must hold
    clear_frame();
    fr_re[3] = 500; fr_re[7] = 600;
    run_frame(10, -1);
    idle(8);
    chk_outs("short", 10, 2, 75, 6);

    // Overflow at beat 12 discards the frame; an identical clean frame publishes
    clear_frame();
    fr_re[3] = 900; fr_re[8] = 700;
    run_frame(16, 12);
    idle(6);
    chk_outs("ovf", 10, 2, 75, 6);
    run_frame(16, -1);
    idle(6);
    chk_outs("after_ovf", 900, 3, 700, 8);

    // Two back-to-back frames with zero gap
    clear_frame();
    fr_re[5] = 300;   fr_im[5] = 300;
    fr_re[9] = -1000; fr_im[9] = 10;
    run_frame(16, -1);
    clear_frame();
    fr_im[2] = -7;
    fr_re[6] = 64; fr_im[6] = -64;
    run_frame(16, -1);
    idle(8);
    chk_outs("b2b", 7, 2, 96, 6);

    // Third frame interrupted by reset at beat 5: no strobe, outputs cleared
    clear_frame();
    fr_re[4] = 333; fr_re[7] = 444;
    for (int b = 0; b < 5; b++) drive_beat(fr_re[b], fr_im[b], 1'b0);
    @(negedge clk);
    reset_n        = 1'b0;
    dut_if.fft_x   = '0;
    dut_if.fft_nd  = 1'b0;
    dut_if.fft_ovf = 1'b0;
    h730 = 0; hi730 = 0; h850 = 0; hi850 = 0;
    repeat (2) @(negedge clk);
    chk_outs("mid_reset", 0, 0, 0, 0);
    reset_n = 1'b1;
    idle(10);
    chk_outs("post_reset", 0, 0, 0, 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
